// File: rtl/seven_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_display_arbiter
// Purpose  : Shares one 8-digit seven-segment display between three sources:
//            live entry (background), computed result (timed hold) and
//            alert/error (timed hold, highest priority). All display outputs
//            come from one registered set and the block owns all hold timing.
// Options  : SEVEN_SEG_ALERT_BLINK_EN adds the disp_blank output, which
//            toggles every BLINK_MS ms while an alert is shown.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_display_arbiter #(
  parameter int CLKS_PER_MS    = 100000,
  parameter int RESULT_HOLD_MS = 3000,
  parameter int ALERT_HOLD_MS  = 2000
`ifdef SEVEN_SEG_ALERT_BLINK_EN
  ,parameter int BLINK_MS      = 250
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] live_number,
  input  logic        live_mode,
  input  logic [7:0]  live_points,
  input  logic        result_req,
  input  logic [31:0] result_number,
  input  logic        result_mode,
  input  logic [7:0]  result_points,
  input  logic        alert_req,
  input  logic [31:0] alert_number,
  input  logic        alert_mode,
  input  logic [7:0]  alert_points,
  input  logic        ack,
  output logic [31:0] disp_number,
  output logic        disp_mode,
  output logic [7:0]  disp_points,
  output logic [1:0]  owner,
  output logic        result_pending
`ifdef SEVEN_SEG_ALERT_BLINK_EN
  ,output logic       disp_blank
`endif
);

  localparam int              PRESC_W     = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLKS_PER_MS - 1);
  localparam logic [15:0]     RESULT_LOAD = 16'(RESULT_HOLD_MS);
  localparam logic [15:0]     ALERT_LOAD  = 16'(ALERT_HOLD_MS);

  // State encoding doubles as the owner code presented on the port.
  localparam logic [1:0] ST_LIVE   = 2'd0;
  localparam logic [1:0] ST_RESULT = 2'd1;
  localparam logic [1:0] ST_ALERT  = 2'd2;

  logic [1:0]         state_q,    state_d;
  logic [PRESC_W-1:0] presc_q,    presc_d;
  logic [15:0]        hold_q,     hold_d;
  logic [31:0]        num_q,      num_d;
  logic               mode_q,     mode_d;
  logic [7:0]         pts_q,      pts_d;
  logic               pend_q,     pend_d;
  logic [31:0]        pend_num_q, pend_num_d;
  logic               pend_mode_q, pend_mode_d;
  logic [7:0]         pend_pts_q, pend_pts_d;
`ifdef SEVEN_SEG_ALERT_BLINK_EN
  localparam logic [15:0] BLINK_MAX = 16'(BLINK_MS - 1);
  logic [15:0]        blink_cnt_q, blink_cnt_d;
  logic               blank_q,     blank_d;
`endif

  logic tick;
  logic expire;
  logic take_alert;
  logic take_result;
  logic queue_result;
  logic release_hold;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_LIVE;
      presc_q     <= '0;
      hold_q      <= '0;
      num_q       <= '0;
      mode_q      <= 1'b0;
      pts_q       <= '0;
      pend_q      <= 1'b0;
      pend_num_q  <= '0;
      pend_mode_q <= 1'b0;
      pend_pts_q  <= '0;
`ifdef SEVEN_SEG_ALERT_BLINK_EN
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      pts_q       <= pts_d;
      pend_q      <= pend_d;
      pend_num_q  <= pend_num_d;
      pend_mode_q <= pend_mode_d;
      pend_pts_q  <= pend_pts_d;
`ifdef SEVEN_SEG_ALERT_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
`endif
    end
  end

  // Next-state, hold timing and display latch selection.
  always_comb begin
    tick   = (presc_q == PRESC_MAX);
    expire = tick && (hold_q == 16'd1);

    // Requests always beat ack/expiry in the same cycle; alert beats result.
    take_alert   = alert_req;
    take_result  = result_req && !alert_req && (state_q != ST_ALERT);
    queue_result = result_req && (alert_req || (state_q == ST_ALERT));
    release_hold = (ack || expire) && !alert_req && !result_req && (state_q != ST_LIVE);

    state_d     = state_q;
    presc_d     = tick ? '0 : presc_q + 1'b1;
    hold_d      = (tick && (hold_q != 16'd0)) ? hold_q - 16'd1 : hold_q;
    num_d       = num_q;
    mode_d      = mode_q;
    pts_d       = pts_q;
    pend_d      = pend_q;
    pend_num_d  = pend_num_q;
    pend_mode_d = pend_mode_q;
    pend_pts_d  = pend_pts_q;

    if (take_alert) begin
      state_d = ST_ALERT;
      num_d   = alert_number;
      mode_d  = alert_mode;
      pts_d   = alert_points;
      hold_d  = ALERT_LOAD;
      presc_d = '0;
    end else if (take_result) begin
      state_d = ST_RESULT;
      num_d   = result_number;
      mode_d  = result_mode;
      pts_d   = result_points;
      hold_d  = RESULT_LOAD;
      presc_d = '0;
    end else if (release_hold) begin
      if ((state_q == ST_ALERT) && pend_q) begin
        // A result queued behind the alert gets its full hold now.
        state_d = ST_RESULT;
        num_d   = pend_num_q;
        mode_d  = pend_mode_q;
        pts_d   = pend_pts_q;
        hold_d  = RESULT_LOAD;
        presc_d = '0;
        pend_d  = 1'b0;
      end else begin
        state_d = ST_LIVE;
        hold_d  = '0;
      end
    end

    // Last queued result wins.
    if (queue_result) begin
      pend_d      = 1'b1;
      pend_num_d  = result_number;
      pend_mode_d = result_mode;
      pend_pts_d  = result_points;
    end

    // Live entry is tracked every cycle whenever live owns the display.
    if (state_d == ST_LIVE) begin
      num_d  = live_number;
      mode_d = live_mode;
      pts_d  = live_points;
    end

`ifdef SEVEN_SEG_ALERT_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if ((state_d != ST_ALERT) || take_alert) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
`endif
  end

  // Outputs come straight from registers.
  always_comb begin
    disp_number    = num_q;
    disp_mode      = mode_q;
    disp_points    = pts_q;
    owner          = state_q;
    result_pending = pend_q;
`ifdef SEVEN_SEG_ALERT_BLINK_EN
    disp_blank     = blank_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_display_arbiter
// Purpose  : Directed self-checking bench for seven_seg_display_arbiter with
//            CLKS_PER_MS=4, RESULT_HOLD_MS=3, ALERT_HOLD_MS=2 (BLINK_MS=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_display_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] live_number = '0;
  logic        live_mode = 1'b0;
  logic [7:0]  live_points = '0;
  logic        result_req = 1'b0;
  logic [31:0] result_number = '0;
  logic        result_mode = 1'b0;
  logic [7:0]  result_points = 8'h20;
  logic        alert_req = 1'b0;
  logic [31:0] alert_number = '0;
  logic        alert_mode = 1'b1;
  logic [7:0]  alert_points = 8'hFF;
  logic        ack = 1'b0;
  logic [31:0] disp_number;
  logic        disp_mode;
  logic [7:0]  disp_points;
  logic [1:0]  owner;
  logic        result_pending;
`ifdef SEVEN_SEG_ALERT_BLINK_EN
  logic        disp_blank;
`endif

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] num;
    logic        mode;
    logic [7:0]  pts;
    logic        pend;
    logic        blank;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_blank = 1'b0;

  seven_seg_display_arbiter #(
    .CLKS_PER_MS    (4),
    .RESULT_HOLD_MS (3),
    .ALERT_HOLD_MS  (2)
`ifdef SEVEN_SEG_ALERT_BLINK_EN
    ,.BLINK_MS      (1)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .live_number    (live_number),
    .live_mode      (live_mode),
    .live_points    (live_points),
    .result_req     (result_req),
    .result_number  (result_number),
    .result_mode    (result_mode),
    .result_points  (result_points),
    .alert_req      (alert_req),
    .alert_number   (alert_number),
    .alert_mode     (alert_mode),
    .alert_points   (alert_points),
    .ack            (ack),
    .disp_number    (disp_number),
    .disp_mode      (disp_mode),
    .disp_points    (disp_points),
    .owner          (owner),
    .result_pending (result_pending)
`ifdef SEVEN_SEG_ALERT_BLINK_EN
    ,.disp_blank    (disp_blank)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the next edge, clock once, then compare.
  // Request/ack pulses are single-cycle, so they are dropped after the edge.
  task automatic cyc(input logic [1:0] o, input logic [31:0] n, input logic m,
                     input logic [7:0] p, input logic pend);
    exp_t e;
    e.owner = o; e.num = n; e.mode = m; e.pts = p; e.pend = pend; e.blank = exp_blank;
    sb.push_back(e);
    @(posedge clock);
    #1;
    result_req = 1'b0;
    alert_req  = 1'b0;
    ack        = 1'b0;
    e = sb.pop_front();
    chk("owner",          {30'd0, owner},       {30'd0, e.owner});
    chk("disp_number",    disp_number,          e.num);
    chk("disp_mode",      {31'd0, disp_mode},   {31'd0, e.mode});
    chk("disp_points",    {24'd0, disp_points}, {24'd0, e.pts});
    chk("result_pending", {31'd0, result_pending}, {31'd0, e.pend});
`ifdef SEVEN_SEG_ALERT_BLINK_EN
    chk("disp_blank",     {31'd0, disp_blank},  {31'd0, e.blank});
`endif
  endtask

  task automatic live_c();
    cyc(2'd0, live_number, live_mode, live_points, 1'b0);
  endtask

  task automatic res_c(input logic [31:0] n, input logic pend);
    cyc(2'd1, n, 1'b0, 8'h20, pend);
  endtask

  task automatic alr_c(input logic [31:0] n, input logic pend);
    cyc(2'd2, n, 1'b1, 8'hFF, pend);
  endtask

  initial begin
    // Reset: live inputs are non-zero but outputs must stay cleared.
    live_number = 32'h0000_1234; live_mode = 1'b1; live_points = 8'h0F;
    cyc(2'd0, 32'h0, 1'b0, 8'h00, 1'b0);
    cyc(2'd0, 32'h0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;

    // Live tracking
    live_c();
    live_number = 32'h0000_0055;
    live_c();

    // Result hold: exactly 12 cycles, latched value survives input change
    result_number = 32'h0000_0042; result_req = 1'b1;
    res_c(32'h42, 1'b0);
    result_number = 32'h0000_0077;
    for (int i = 0; i < 11; i++) res_c(32'h42, 1'b0);
    live_c();

    // Alert preempts result; result queued two cycles later
    result_number = 32'h0000_0042; result_req = 1'b1;
    res_c(32'h42, 1'b0);
    res_c(32'h42, 1'b0);
    alert_number = 32'hEEEE_EEEE; alert_req = 1'b1;
    alr_c(32'hEEEE_EEEE, 1'b0);
    alr_c(32'hEEEE_EEEE, 1'b0);
    result_number = 32'h0000_0099; result_req = 1'b1;
    alr_c(32'hEEEE_EEEE, 1'b1);
    alr_c(32'hEEEE_EEEE, 1'b1);
    exp_blank = 1'b1;
    for (int i = 0; i < 4; i++) alr_c(32'hEEEE_EEEE, 1'b1);
    exp_blank = 1'b0;
    for (int i = 0; i < 12; i++) res_c(32'h99, 1'b0);
    live_c();

    // Ack three cycles into an alert with nothing pending, then ack in live
    alert_req = 1'b1;
    alr_c(32'hEEEE_EEEE, 1'b0);
    alr_c(32'hEEEE_EEEE, 1'b0);
    alr_c(32'hEEEE_EEEE, 1'b0);
    ack = 1'b1;
    live_c();
    live_number = 32'h0000_0066; ack = 1'b1;
    live_c();

    // Collision: alert and result together, then ack releases the result
    alert_number = 32'hAAAA_0000; result_number = 32'h0000_1111;
    alert_req = 1'b1; result_req = 1'b1;
    alr_c(32'hAAAA_0000, 1'b1);
    ack = 1'b1;
    for (int i = 0; i < 12; i++) res_c(32'h1111, 1'b0);
    // Request on the expiry cycle restarts a full hold
    result_number = 32'h0000_2222; result_req = 1'b1;
    for (int i = 0; i < 12; i++) res_c(32'h2222, 1'b0);
    live_c();

    // Reset mid-alert with a pending result; pending is lost
    alert_number = 32'h0000_00E1; alert_req = 1'b1;
    alr_c(32'hE1, 1'b0);
    result_number = 32'h0000_0033; result_req = 1'b1;
    alr_c(32'hE1, 1'b1);
    reset = 1'b1;
    cyc(2'd0, 32'h0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    live_c();
    alert_req = 1'b1;
    alr_c(32'hE1, 1'b0);
    ack = 1'b1;
    live_c();

    // Full alert expiry; blink half-period of 4 cycles when enabled
    alert_req = 1'b1;
    for (int i = 0; i < 4; i++) alr_c(32'hE1, 1'b0);
    exp_blank = 1'b1;
    for (int i = 0; i < 4; i++) alr_c(32'hE1, 1'b0);
    exp_blank = 1'b0;
    live_c();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_display_arbiter.md
Name: seven_seg_display_arbiter

Overview:
- Shares the 8-digit seven_seg_fsm display between three sources: live entry (background), computed result (timed hold) and alert/error (timed hold, highest priority).
- Drives the display's input_number, mode and dec_points from one registered output set.
- Sits between the calculator core and seven_seg_fsm, and owns all hold timing.

Parameters:
- CLKS_PER_MS, 100000, clock cycles per millisecond tick (100 MHz board clock).
- RESULT_HOLD_MS, 3000, result display duration in ms; range 1..65535.
- ALERT_HOLD_MS, 2000, alert display duration in ms; range 1..65535.
- BLINK_MS, 250, blink half-period in ms (optional feature only).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- live_number  in  32  live entry value, sampled every cycle.
- live_mode  in  1  0 = decimal, 1 = hex, for live entry.
- live_points  in  8  decimal points for live entry.
- result_req  in  1  single-cycle pulse: latch result_* and show it.
- result_number  in  32  result value.
- result_mode  in  1  result mode.
- result_points  in  8  result decimal points.
- alert_req  in  1  single-cycle pulse: latch alert_* and show it.
- alert_number  in  32  alert pattern/code.
- alert_mode  in  1  alert mode.
- alert_points  in  8  alert decimal points.
- ack  in  1  user acknowledge; ends the current hold early.
- disp_number  out  32  to seven_seg_fsm input_number.
- disp_mode  out  1  to seven_seg_fsm mode.
- disp_points  out  8  to seven_seg_fsm dec_points.
- owner  out  2  current source: 0 = live, 1 = result, 2 = alert.
- result_pending  out  1  a result is queued behind an alert.

Behaviour:
- Reset:
  - Outputs: disp_number = 0, disp_mode = 0, disp_points = 0, owner = 0, result_pending = 0.
  - Internal: state LIVE, prescaler = 0, hold counter = 0, pending buffer cleared.
- All outputs are registered; a source change appears 1 cycle after the causing input edge.
- Prescaler:
  - Counts 0..CLKS_PER_MS-1 and asserts the ms tick at the wrap.
  - It is cleared whenever the hold counter loads, so a hold lasts exactly HOLD_MS*CLKS_PER_MS cycles.
- Hold counter:
  - 16 bits; loads HOLD_MS on entry to or restart of a hold state.
  - Decrements on each tick.
  - On the tick where it goes 1 -> 0, the state exits in that same cycle.
- LIVE state (owner 0):
  - disp_* <= live_* every cycle.
  - result_req -> RESULT, latching result_*.
  - alert_req -> ALERT.
  - ack is ignored.
- RESULT state (owner 1):
  - disp_* hold the latched result.
  - A new result_req re-latches the result and restarts the hold counter.
  - alert_req -> ALERT; the currently shown result is discarded, not queued.
  - ack or expiry -> LIVE.
- ALERT state (owner 2):
  - disp_* hold the latched alert.
  - A new alert_req re-latches the alert and restarts the hold counter.
  - result_req writes the pending buffer (last one wins) and sets result_pending = 1.
- Exit from ALERT (ack or expiry):
  - If result_pending: go to RESULT with the pending value, load RESULT_HOLD_MS, clear result_pending.
  - Otherwise: go to LIVE.
- Simultaneous events, same cycle:
  - alert_req + result_req: alert wins; the result goes to the pending buffer.
  - Any req + expiry, or any req + ack: the request wins, and ack/expiry is ignored for that cycle.
  - result_req + ack in RESULT: the result is re-latched and the hold restarts.
- Reset asserted mid-hold: returns to the reset values on the next edge; the pending buffer is lost.

Optional Feature:
- Macro: SEVEN_SEG_ALERT_BLINK_EN.
- Defined:
  - Adds output port disp_blank (1 bit), reset 0.
  - In ALERT, disp_blank toggles every BLINK_MS ms, using a separate blink counter driven by the same tick; it starts at 0 on ALERT entry or restart.
  - Outside ALERT, disp_blank = 0.
  - The top level gates the anodes with disp_blank.
- Not defined: no disp_blank port and no blink counter; alert shows steadily.

Test Plan:
All scenarios use CLKS_PER_MS=4, RESULT_HOLD_MS=3, ALERT_HOLD_MS=2.
- Live tracking: reset, then live_number = 0x00001234, live_mode = 1 -> next cycle disp_number = 0x00001234, disp_mode = 1, owner = 0; changing live_number to 0x55 appears 1 cycle later.
- Result hold: result_req with 0x00000042 -> owner = 1 and disp_number = 0x42 for exactly 12 cycles, then owner = 0 and disp shows live_number.
- Alert preempts and queues: during RESULT, alert_req 0xEEEEEEEE, then result_req 0x99 two cycles later -> owner = 2 for 8 cycles with result_pending = 1; then owner = 1, disp_number = 0x99 for 12 cycles, result_pending = 0.
- Ack: ack 3 cycles into ALERT with nothing pending -> next cycle owner = 0; ack in LIVE -> no change.
- Collisions: alert_req and result_req in the same cycle -> owner = 2, result_pending = 1. result_req on the expiry cycle of RESULT -> owner stays 1, new value shown, full 12-cycle hold restarts.
- Reset mid-alert with a pending result -> next cycle owner = 0, result_pending = 0, disp_number = 0. With SEVEN_SEG_ALERT_BLINK_EN and BLINK_MS = 1: disp_blank toggles every 4 cycles in ALERT and is 0 after exit.
